// File: rtl/atmega_eep_backup.sv
// EEPROM persistence engine: restores the array from the host at power-up and
// streams it back to the host after CPU writes settle for HOLDOFF cycles.
module atmega_eep_backup #(
    parameter int unsigned EEP_SIZE  = 512,
    parameter int unsigned ADDR_W    = 9,
    parameter int unsigned HOLDOFF   = 1024,
    parameter bit          AUTO_SAVE = 1'b1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              eep_wr_strobe,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_rd,
    input  logic [7:0]        mem_rdata,
    output logic              mem_wr,
    output logic [7:0]        mem_wdata,
    output logic              cpu_hold,
    input  logic              load_start,
    input  logic              ld_valid,
    input  logic [7:0]        ld_data,
    output logic              ld_ready,
    input  logic              save_req,
    output logic              sv_valid,
    output logic [7:0]        sv_data,
    output logic              sv_last,
    input  logic              sv_ready,
    output logic              dirty,
    output logic              busy,
    output logic              done
);

    localparam int unsigned       CNT_W      = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;
    localparam logic [CNT_W-1:0]  CNT_RELOAD = CNT_W'(HOLDOFF - 1);
    localparam logic [ADDR_W-1:0] LAST_ADDR  = ADDR_W'(EEP_SIZE - 1);

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_HOLDOFF,
        ST_SAVE_RD,
        ST_SAVE_WAIT,
        ST_SAVE_OUT
    } state_t;

    state_t            state, state_nxt;
    logic [ADDR_W-1:0] addr, addr_nxt;
    logic [CNT_W-1:0]  cnt, cnt_nxt;
    logic              done_nxt;
    logic              clear_dirty;

    assign mem_addr = addr;
    assign busy     = (state == ST_LOAD) || (state == ST_SAVE_RD) ||
                      (state == ST_SAVE_WAIT) || (state == ST_SAVE_OUT);

    always_comb begin
        state_nxt   = state;
        addr_nxt    = addr;
        cnt_nxt     = cnt;
        done_nxt    = 1'b0;
        clear_dirty = 1'b0;
        mem_rd      = 1'b0;
        mem_wr      = 1'b0;
        mem_wdata   = '0;
        ld_ready    = 1'b0;
        cpu_hold    = 1'b0;
        sv_valid    = 1'b0;
        sv_last     = 1'b0;
        case (state)
            ST_IDLE: begin
                if (load_start) begin
                    state_nxt   = ST_LOAD;
                    addr_nxt    = '0;
                    clear_dirty = 1'b1;
                end else if (save_req) begin
                    state_nxt   = ST_SAVE_RD;
                    addr_nxt    = '0;
                    clear_dirty = 1'b1;
                end else if (dirty) begin
                    state_nxt = ST_HOLDOFF;
                    cnt_nxt   = CNT_RELOAD;
                end
            end
            ST_HOLDOFF: begin
                if (load_start) begin
                    state_nxt   = ST_LOAD;
                    addr_nxt    = '0;
                    clear_dirty = 1'b1;
                end else if (save_req) begin
                    state_nxt   = ST_SAVE_RD;
                    addr_nxt    = '0;
                    clear_dirty = 1'b1;
                end else if (eep_wr_strobe) begin
                    cnt_nxt = CNT_RELOAD;
                end else if (cnt == '0) begin
                    // Without auto-save, dirty stays set so the host can still see pending data
                    if (AUTO_SAVE) begin
                        state_nxt   = ST_SAVE_RD;
                        addr_nxt    = '0;
                        clear_dirty = 1'b1;
                    end else begin
                        state_nxt = ST_IDLE;
                    end
                end else begin
                    cnt_nxt = cnt - 1'b1;
                end
            end
            ST_LOAD: begin
                cpu_hold = 1'b1;
                ld_ready = 1'b1;
                if (ld_valid) begin
                    mem_wr    = 1'b1;
                    mem_wdata = ld_data;
                    addr_nxt  = addr + 1'b1;
                    if (addr == LAST_ADDR) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end
                end
            end
            ST_SAVE_RD: begin
                mem_rd    = 1'b1;
                state_nxt = ST_SAVE_WAIT;
            end
            ST_SAVE_WAIT: begin
                state_nxt = ST_SAVE_OUT;
            end
            ST_SAVE_OUT: begin
                sv_valid = 1'b1;
                sv_last  = (addr == LAST_ADDR);
                if (sv_ready) begin
                    if (addr == LAST_ADDR) begin
                        state_nxt = ST_IDLE;
                        done_nxt  = 1'b1;
                    end else begin
                        addr_nxt  = addr + 1'b1;
                        state_nxt = ST_SAVE_RD;
                    end
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= ST_IDLE;
            addr    <= '0;
            cnt     <= '0;
            dirty   <= 1'b0;
            done    <= 1'b0;
            sv_data <= '0;
        end else begin
            state <= state_nxt;
            addr  <= addr_nxt;
            cnt   <= cnt_nxt;
            done  <= done_nxt;
            // A CPU write in the same cycle as a clear must not be lost
            if (eep_wr_strobe) begin
                dirty <= 1'b1;
            end else if (clear_dirty) begin
                dirty <= 1'b0;
            end
            if (state == ST_SAVE_WAIT) begin
                sv_data <= mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_atmega_eep_backup.sv
// Self-checking bench for atmega_eep_backup (8-byte array, HOLDOFF=4, auto-save on).
module tb_atmega_eep_backup;

    localparam int unsigned N  = 8;
    localparam int unsigned HO = 4;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       eep_wr_strobe = 1'b0;
    logic [2:0] mem_addr;
    logic       mem_rd;
    logic [7:0] mem_rdata = '0;
    logic       mem_wr;
    logic [7:0] mem_wdata;
    logic       cpu_hold;
    logic       load_start = 1'b0;
    logic       ld_valid = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_ready;
    logic       save_req = 1'b0;
    logic       sv_valid;
    logic [7:0] sv_data;
    logic       sv_last;
    logic       sv_ready = 1'b0;
    logic       dirty;
    logic       busy;
    logic       done;

    // CPU-side port of the array model
    logic       cpu_we = 1'b0;
    logic [2:0] cpu_addr = '0;
    logic [7:0] cpu_data = '0;

    logic [7:0] arr [N];
    logic [7:0] ref_arr [N];
    logic [7:0] ld_bytes [N];
    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    atmega_eep_backup #(
        .EEP_SIZE (N),
        .ADDR_W   (3),
        .HOLDOFF  (HO),
        .AUTO_SAVE(1'b1)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .eep_wr_strobe(eep_wr_strobe),
        .mem_addr     (mem_addr),
        .mem_rd       (mem_rd),
        .mem_rdata    (mem_rdata),
        .mem_wr       (mem_wr),
        .mem_wdata    (mem_wdata),
        .cpu_hold     (cpu_hold),
        .load_start   (load_start),
        .ld_valid     (ld_valid),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .save_req     (save_req),
        .sv_valid     (sv_valid),
        .sv_data      (sv_data),
        .sv_last      (sv_last),
        .sv_ready     (sv_ready),
        .dirty        (dirty),
        .busy         (busy),
        .done         (done)
    );

    always @(posedge clk) begin
        if (mem_wr) arr[mem_addr] <= mem_wdata;
        if (cpu_we) arr[cpu_addr] <= cpu_data;
        if (mem_rd) mem_rdata <= arr[mem_addr];
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_busy(output int k);
        k = 0;
        while (!busy && k < 64) begin
            tick();
            k++;
        end
    endtask

    // Restore ld_bytes from the host; optional gaps in ld_valid.
    task automatic load_run(input bit gaps, input bit with_save_req);
        int idx = 0;
        int guard = 0;
        load_start = 1'b1;
        save_req   = with_save_req;
        tick();
        load_start = 1'b0;
        save_req   = 1'b0;
        check("load_no_save", sv_valid, 1'b0);
        while (idx < int'(N) && guard < 200) begin
            ld_valid = gaps ? ($urandom_range(3) != 0) : 1'b1;
            ld_data  = ld_valid ? ld_bytes[idx] : 8'($urandom);
            #1;
            check("load_cpu_hold", cpu_hold, 1'b1);
            check("load_ld_ready", ld_ready, 1'b1);
            check("load_busy", busy, 1'b1);
            check("load_mem_wr", mem_wr, ld_valid);
            check("load_mem_rd", mem_rd, 1'b0);
            if (ld_valid) begin
                check("load_addr", mem_addr, idx);
                check("load_wdata", mem_wdata, ld_bytes[idx]);
            end
            tick();
            if (ld_valid) begin
                ref_arr[idx] = ld_bytes[idx];
                idx++;
            end
            guard++;
        end
        ld_valid = 1'b0;
        check("load_bytes", idx, N);
        check("load_done", done, 1'b1);
        check("load_hold_drop", cpu_hold, 1'b0);
        check("load_busy_end", busy, 1'b0);
        check("load_dirty", dirty, 1'b0);
        tick();
        check("load_done_pulse", done, 1'b0);
    endtask

    // Stream one save. mode 0: always ready, 1: random ready, 2: stall byte 3 for 5 cycles.
    // poke_byte >= 0: CPU rewrites byte 0 while that byte is being offered.
    task automatic save_run(input int mode, input int poke_byte);
        logic [7:0] exp [N];
        logic [7:0] prev_data = '0;
        bit prev_stall = 1'b0;
        bit poked = 1'b0;
        int hs = 0;
        int cyc = 0;
        int last = 0;
        int stall = 0;
        for (int i = 0; i < int'(N); i++) exp[i] = ref_arr[i];
        check("save_busy_start", busy, 1'b1);
        while (hs < int'(N) && cyc < 400) begin
            case (mode)
                0: sv_ready = 1'b1;
                1: sv_ready = 1'($urandom_range(1));
                default: begin
                    if (sv_valid && hs == 3 && stall < 5) begin
                        sv_ready = 1'b0;
                        stall++;
                    end else begin
                        sv_ready = 1'b1;
                    end
                end
            endcase
            if (poke_byte >= 0 && sv_valid && hs == poke_byte && !poked) begin
                eep_wr_strobe = 1'b1;
                cpu_we   = 1'b1;
                cpu_addr = '0;
                cpu_data = ref_arr[0] ^ 8'hFF;
                ref_arr[0] = cpu_data;
                poked = 1'b1;
            end
            #1;
            check("save_busy", busy, 1'b1);
            check("rd_wr_excl", mem_rd & mem_wr, 1'b0);
            if (prev_stall) begin
                check("hold_valid", sv_valid, 1'b1);
                check("hold_data", sv_data, prev_data);
            end
            if (sv_valid) begin
                check("save_data", sv_data, exp[hs]);
                check("save_last", sv_last, hs == int'(N) - 1);
            end
            prev_stall = sv_valid && !sv_ready;
            prev_data  = sv_data;
            if (sv_valid && sv_ready) begin
                if (hs > 0) check("save_rate", (cyc - last) >= 3, 1'b1);
                last = cyc;
                hs++;
            end
            tick();
            eep_wr_strobe = 1'b0;
            cpu_we = 1'b0;
            cyc++;
        end
        sv_ready = 1'b0;
        check("save_handshakes", hs, N);
        check("save_done", done, 1'b1);
        check("save_busy_end", busy, 1'b0);
        check("save_valid_end", sv_valid, 1'b0);
    endtask

    task automatic pulse_save();
        save_req = 1'b1;
        tick();
        save_req = 1'b0;
    endtask

    task automatic pulse_strobe();
        eep_wr_strobe = 1'b1;
        tick();
        eep_wr_strobe = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "simulation did not finish");
    end

    initial begin
        int k;
        repeat (2) tick();
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_dirty", dirty, 1'b0);
        check("rst_sv_valid", sv_valid, 1'b0);
        check("rst_sv_data", sv_data, 8'h00);
        check("rst_sv_last", sv_last, 1'b0);
        check("rst_cpu_hold", cpu_hold, 1'b0);
        check("rst_ld_ready", ld_ready, 1'b0);
        check("rst_mem", {mem_wr, mem_rd, mem_addr, mem_wdata}, '0);
        rst = 1'b1;
        tick();

        // Load 0x10..0x17 back to back
        for (int i = 0; i < int'(N); i++) ld_bytes[i] = 8'(8'h10 + i);
        load_run(1'b0, 1'b0);

        // Array now 0xA0+i via the CPU port; one strobe triggers auto-save
        for (int i = 0; i < int'(N); i++) begin
            cpu_we = 1'b1; cpu_addr = 3'(i); cpu_data = 8'(8'hA0 + i);
            ref_arr[i] = cpu_data;
            tick();
        end
        cpu_we = 1'b0;
        check("idle_clean", busy | dirty, 1'b0);
        pulse_strobe();
        check("strobe_dirty", dirty, 1'b1);
        wait_busy(k);
        check("auto_delay", k, HO + 1);
        save_run(0, -1);
        check("auto_dirty_clr", dirty, 1'b0);

        // Backpressure on byte 3
        pulse_save();
        save_run(2, -1);
        check("bp_dirty", dirty, 1'b0);

        // Strobe together with save_req: set beats clear, follow-up save after holdoff
        pulse_strobe();
        save_req = 1'b1;
        eep_wr_strobe = 1'b1;
        tick();
        save_req = 1'b0;
        eep_wr_strobe = 1'b0;
        check("prio_dirty_set", dirty, 1'b1);
        save_run(1, -1);
        wait_busy(k);
        check("prio_followup", k, HO + 1);
        save_run(0, -1);
        check("prio_dirty_clr", dirty, 1'b0);

        // CPU write while streaming byte 2
        pulse_save();
        save_run(1, 2);
        check("wds_dirty", dirty, 1'b1);
        wait_busy(k);
        check("wds_followup", k, HO + 1);
        save_run(0, -1);
        check("wds_dirty_clr", dirty, 1'b0);

        // Holdoff retrigger: three strobes three cycles apart
        for (int s = 0; s < 3; s++) begin
            pulse_strobe();
            if (s < 2) begin
                for (int j = 0; j < 2; j++) begin
                    check("retrig_idle", busy, 1'b0);
                    tick();
                end
            end
        end
        wait_busy(k);
        check("retrig_delay", k, HO);
        save_run(1, -1);
        check("retrig_dirty", dirty, 1'b0);

        // Randomized loads (first with simultaneous save_req) and saves
        for (int it = 0; it < 3; it++) begin
            for (int i = 0; i < int'(N); i++) ld_bytes[i] = 8'($urandom);
            load_run(1'b1, it == 0);
            repeat ($urandom_range(3)) tick();
            check("rand_idle", busy, 1'b0);
            pulse_save();
            save_run(1, -1);
            check("rand_dirty", dirty, 1'b0);
        end

        // Reset in the middle of a load
        load_start = 1'b1;
        tick();
        load_start = 1'b0;
        ld_valid = 1'b1;
        ld_data = 8'h5A;
        tick();
        ref_arr[0] = 8'h5A;
        ld_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        check("rstld_cpu_hold", cpu_hold, 1'b0);
        check("rstld_busy", busy, 1'b0);
        check("rstld_ld_ready", ld_ready, 1'b0);
        rst = 1'b1;
        tick();

        // Reset during SAVE_OUT with a pending CPU write
        pulse_save();
        for (int g = 0; g < 20 && !sv_valid; g++) tick();
        check("rstsv_valid_pre", sv_valid, 1'b1);
        pulse_strobe();
        check("rstsv_dirty_pre", dirty, 1'b1);
        #2 rst = 1'b0;
        #1;
        check("rstsv_valid", sv_valid, 1'b0);
        check("rstsv_busy", busy, 1'b0);
        check("rstsv_cpu_hold", cpu_hold, 1'b0);
        check("rstsv_dirty", dirty, 1'b0);
        rst = 1'b1;
        tick();
        check("rel_busy", busy, 1'b0);
        check("rel_dirty", dirty, 1'b0);
        repeat (HO + 3) tick();
        check("rel_stays_idle", busy, 1'b0);
        pulse_save();
        save_run(0, -1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
